// File: rtl/if_id_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage_if
// Brief    : Fetch-side inputs and decode-side outputs of the IF/ID register.
// Revision : 1.0
// ============================================================================
interface if_id_stage_if #(
    parameter int PC_W = 10
);
    logic [31:0]     instr_in;
    logic [PC_W-1:0] pc_in;
    logic            fetch_valid;
    logic            stop;
    logic            flush;
    logic [31:0]     instr_out;
    logic [PC_W-1:0] pc_out;
    logic            valid_out;
    logic [9:0]      rsrt_id;
    logic            pc_write;
    logic            bubble;
    logic [15:0]     stall_count;

    modport master (
        output instr_in, pc_in, fetch_valid, stop, flush,
        input  instr_out, pc_out, valid_out, rsrt_id, pc_write, bubble, stall_count
    );

    modport slave (
        input  instr_in, pc_in, fetch_valid, stop, flush,
        output instr_out, pc_out, valid_out, rsrt_id, pc_write, bubble, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage
// Brief    : IF/ID pipeline register with one-cycle load-use stall and flush.
// Revision : 1.0
// ============================================================================
module if_id_stage #(
    parameter int          PC_W = 10,
    parameter logic [31:0] NOP  = 32'h0000_0000
) (
    input  wire logic    clk,
    input  wire logic    reset,
    if_id_stage_if.slave bus
);
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    state_t          r_state;
    logic [31:0]     r_instr;
    logic [PC_W-1:0] r_pc;
    logic            r_valid;
    logic [15:0]     r_stall_count;
    logic            w_stall_req;

    // Stop only matters for a real instruction in RUN; a pending flush kills it.
    assign w_stall_req = bus.stop & r_valid & (r_state == ST_RUN) & ~bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_instr       <= NOP;
            r_pc          <= '0;
            r_valid       <= 1'b0;
            r_stall_count <= '0;
        end else if (bus.flush) begin
            r_state <= ST_RUN;
            r_instr <= NOP;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (w_stall_req) begin
            r_state <= ST_HOLD;
            if (r_stall_count != c_CNT_MAX) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end else begin
            r_state <= ST_RUN;
            r_instr <= bus.instr_in;
            r_pc    <= bus.pc_in;
            r_valid <= bus.fetch_valid;
        end
    end

    assign bus.instr_out   = r_instr;
    assign bus.pc_out      = r_pc;
    assign bus.valid_out   = r_valid;
    assign bus.rsrt_id     = {r_instr[25:21], r_instr[20:16]};
    assign bus.pc_write    = ~w_stall_req;
    assign bus.bubble      = w_stall_req;
    assign bus.stall_count = r_stall_count;
endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_stage
// Brief    : Scoreboard bench for if_id_stage using directed vectors.
// Revision : 1.0
// ============================================================================
module tb_if_id_stage;
    localparam int PC_W = 10;

    typedef struct {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic            fv;
        logic            stop;
        logic            flush;
        logic            e_bubble;
        logic            e_pcw;
        logic [31:0]     e_instr;
        logic [PC_W-1:0] e_pc;
        logic            e_valid;
        logic [9:0]      e_rsrt;
        logic [15:0]     e_cnt;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    vec_t exp_q[$];
    vec_t vecs[16];

    if_id_stage_if #(.PC_W(PC_W)) bus ();

    if_id_stage #(.PC_W(PC_W), .NOP(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [PC_W-1:0] pc,
                                input logic fv, input logic stop, input logic flush,
                                input logic eb, input logic ep, input logic [31:0] ei,
                                input logic [PC_W-1:0] epc, input logic ev,
                                input logic [9:0] ers, input logic [15:0] ec);
        vec_t v;
        v.instr = instr; v.pc = pc; v.fv = fv; v.stop = stop; v.flush = flush;
        v.e_bubble = eb; v.e_pcw = ep; v.e_instr = ei; v.e_pc = epc;
        v.e_valid = ev; v.e_rsrt = ers; v.e_cnt = ec;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        bus.instr_in    = v.instr;
        bus.pc_in       = v.pc;
        bus.fetch_valid = v.fv;
        bus.stop        = v.stop;
        bus.flush       = v.flush;
        exp_q.push_back(v);
    endtask

    // Monitor: same-cycle control outputs before the edge, register contents after it.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("bubble",   {31'd0, bus.bubble},   {31'd0, e.e_bubble});
                chk("pc_write", {31'd0, bus.pc_write}, {31'd0, e.e_pcw});
                @(posedge clk);
                #1;
                chk("instr_out",   bus.instr_out,              e.e_instr);
                chk("pc_out",      {22'd0, bus.pc_out},        {22'd0, e.e_pc});
                chk("valid_out",   {31'd0, bus.valid_out},     {31'd0, e.e_valid});
                chk("rsrt_id",     {22'd0, bus.rsrt_id},       {22'd0, e.e_rsrt});
                chk("stall_count", {16'd0, bus.stall_count},   {16'd0, e.e_cnt});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        checks = 0; failures = 0;
        // instr, pc, fv, stop, flush | bubble, pc_write, instr_out, pc_out, valid, rsrt, count
        vecs[0]  = mk(32'h8C22_0004, 10'd1, 1, 0, 0, 0, 1, 32'h8C22_0004, 10'd1, 1, {5'd1, 5'd2}, 16'd0);
        vecs[1]  = mk(32'h0043_2020, 10'd2, 1, 0, 0, 0, 1, 32'h0043_2020, 10'd2, 1, {5'd2, 5'd3}, 16'd0);
        vecs[2]  = mk(32'h1111_1111, 10'd3, 1, 1, 0, 1, 0, 32'h0043_2020, 10'd2, 1, {5'd2, 5'd3}, 16'd1);
        vecs[3]  = mk(32'h1111_1111, 10'd3, 1, 1, 0, 0, 1, 32'h1111_1111, 10'd3, 1, {5'd8, 5'd17}, 16'd1);
        vecs[4]  = mk(32'h2222_2222, 10'd4, 1, 1, 1, 0, 1, 32'h0000_0000, 10'd0, 0, 10'd0, 16'd1);
        vecs[5]  = mk(32'h3333_3333, 10'd5, 1, 1, 0, 0, 1, 32'h3333_3333, 10'd5, 1, {5'd25, 5'd19}, 16'd1);
        vecs[6]  = mk(32'h4444_4444, 10'd6, 0, 0, 0, 0, 1, 32'h4444_4444, 10'd6, 0, {5'd2, 5'd4}, 16'd1);
        vecs[7]  = mk(32'h5555_5555, 10'd7, 1, 1, 0, 0, 1, 32'h5555_5555, 10'd7, 1, {5'd10, 5'd21}, 16'd1);
        vecs[8]  = mk(32'h6666_6666, 10'd8, 1, 1, 0, 1, 0, 32'h5555_5555, 10'd7, 1, {5'd10, 5'd21}, 16'd2);
        vecs[9]  = mk(32'h7777_7777, 10'd9, 1, 0, 0, 0, 1, 32'h7777_7777, 10'd9, 1, {5'd27, 5'd23}, 16'd0);
        vecs[10] = mk(32'h8888_8888, 10'd10, 1, 1, 0, 1, 0, 32'h7777_7777, 10'd9, 1, {5'd27, 5'd23}, 16'd1);
        vecs[11] = mk(32'h8888_8888, 10'd10, 1, 0, 0, 0, 1, 32'h8888_8888, 10'd10, 1, {5'd4, 5'd8}, 16'd1);
        vecs[12] = mk(32'h9999_9999, 10'd11, 1, 1, 0, 1, 0, 32'h8888_8888, 10'd10, 1, {5'd4, 5'd8}, 16'hFFFF);
        vecs[13] = mk(32'h9999_9999, 10'd11, 1, 0, 0, 0, 1, 32'h9999_9999, 10'd11, 1, {5'd12, 5'd25}, 16'hFFFF);
        vecs[14] = mk(32'hAAAA_AAAA, 10'd12, 1, 1, 0, 1, 0, 32'h9999_9999, 10'd11, 1, {5'd12, 5'd25}, 16'hFFFF);
        vecs[15] = mk(32'hAAAA_AAAA, 10'd12, 1, 0, 0, 0, 1, 32'hAAAA_AAAA, 10'd12, 1, {5'd21, 5'd10}, 16'hFFFF);

        bus.instr_in = 32'h0; bus.pc_in = '0; bus.fetch_valid = 1'b0;
        bus.stop = 1'b1; bus.flush = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_instr_out", bus.instr_out, 32'h0);
        chk("rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
        chk("rst_pc_write",  {31'd0, bus.pc_write},  32'd1);
        chk("rst_bubble",    {31'd0, bus.bubble},    32'd0);
        chk("rst_count",     {16'd0, bus.stall_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i <= 8; i++) apply(vecs[i]);

        // Reset asynchronously between edges while the stage sits in HOLD.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_instr_out", bus.instr_out, 32'h0);
        chk("async_pc_out",    {22'd0, bus.pc_out}, 32'd0);
        chk("async_valid_out", {31'd0, bus.valid_out}, 32'd0);
        chk("async_count",     {16'd0, bus.stall_count}, 32'd0);
        chk("async_pc_write",  {31'd0, bus.pc_write}, 32'd1);
        chk("async_bubble",    {31'd0, bus.bubble}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 9; i <= 11; i++) apply(vecs[i]);

        // Preload the counter just below saturation.
        @(posedge clk);
        #2;
        @(negedge clk);
        force dut.r_stall_count = 16'hFFFE;
        #1;
        release dut.r_stall_count;
        #1;
        chk("preload_count", {16'd0, bus.stall_count}, 32'h0000_FFFE);

        for (int i = 12; i <= 15; i++) apply(vecs[i]);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        @(posedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter PC_W, default 10, width of the program counter values carried through the stage.
REQ-002 Parameter NOP, default 32'h0000_0000, instruction word loaded on reset or flush.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 instr_in  in  32  instruction fetched this cycle.
REQ-006 pc_in  in  PC_W  PC+1 of the fetched instruction.
REQ-007 fetch_valid  in  1  instr_in/pc_in valid this cycle.
REQ-008 stop  in  1  load-use stall request from the hazard detector; combinational, same cycle.
REQ-009 flush  in  1  taken branch/jump resolved in EX; discard the ID-stage instruction.
REQ-010 instr_out  out  32  registered ID-stage instruction.
REQ-011 pc_out  out  PC_W  registered ID-stage PC+1.
REQ-012 valid_out  out  1  ID-stage instruction is real, not a bubble.
REQ-013 rsrt_id  out  10  {instr_out[25:21], instr_out[20:16]}, the source-register fields for the hazard detector.
REQ-014 pc_write  out  1  PC update enable for the fetch stage.
REQ-015 bubble  out  1  zero the ID/EX control word this cycle.
REQ-016 stall_count  out  16  saturating count of stall cycles taken.

Function
REQ-017 FSM states: RUN and HOLD; state is held in a register.
REQ-018 stall_req = stop & valid_out & (state==RUN) & ~flush.
- stop is qualified by valid_out.
- stop is ignored in HOLD.
REQ-019 In RUN with stall_req=1 on a clock edge:
- instr_out, pc_out and valid_out hold their values.
- state becomes HOLD.
- stall_count increments.
REQ-020 In HOLD, the next clock edge always returns state to RUN and loads the IF/ID register normally; every stall lasts exactly one cycle.
REQ-021 Normal load (RUN without stall_req, or HOLD), each edge:
- instr_out <= instr_in.
- pc_out <= pc_in.
- valid_out <= fetch_valid.
REQ-022 flush=1 has priority over stop and over state on the clock edge:
- instr_out <= NOP.
- pc_out <= 0.
- valid_out <= 0.
- state <= RUN.
- stall_count unchanged.
REQ-023 pc_write = ~stall_req; combinational, deasserted only in the cycle stall_req is 1.
REQ-024 bubble = stall_req; combinational, same cycle as the stall request.
REQ-025 rsrt_id is combinational from instr_out and has zero added latency.
REQ-026 stall_count saturates at 16'hFFFF; it does not wrap.
REQ-027 Latency: fetch to instr_out is 1 cycle, or 2 cycles when a stall occurs.

Reset
REQ-028 Asynchronous reset sets the following values, effective without a clock edge:
- instr_out = NOP, pc_out = 0, valid_out = 0.
- state = RUN, stall_count = 0.
REQ-029 While reset is high: pc_write = 1 and bubble = 0 (valid_out = 0 gates stall_req).
REQ-030 Reset asserted mid-HOLD: the stage restarts in RUN after reset release, with no residual stall.

Verification
REQ-031 Stream of fetches 0x8C22_0004, 0x0043_2020 with stop=0 -> each appears on instr_out one cycle later; rsrt_id = {5'd1, 5'd2} for the first; pc_write stays 1.
REQ-032 stop=1 for two consecutive cycles with valid_out=1:
- cycle 1: bubble=1, pc_write=0, instr_out held.
- cycle 2 (HOLD): bubble=0, pc_write=1, stop ignored.
- stall_count = 1.
REQ-033 stop=1 and flush=1 in the same cycle -> bubble=0, pc_write=1; next edge gives instr_out=NOP, valid_out=0, stall_count unchanged.
REQ-034 stop=1 while valid_out=0 (after flush) -> no stall: bubble=0, pc_write=1.
REQ-035 Assert reset asynchronously between edges while in HOLD -> outputs take reset values immediately; the first edge after release loads instr_in with state=RUN.
REQ-036 Preload stall_count near saturation (force to 16'hFFFE), apply two stalls -> stall_count reads 16'hFFFF and stays there.
